// File: rtl/pkt_stream_pkg.sv
// Shared types and helpers for the packet-stream transmit gate.
// The FSM state encoding, default field widths and the beat record live here.
package pkt_stream_pkg;

    localparam int unsigned EMPTY_W_DEF = 6;
    localparam int unsigned DATA_W_DEF  = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        HOLD = 2'd2
    } gate_state_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_W_DEF-1:0] empty;
    } pkt_beat_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pkt_framing_fsm.sv
// Packet framing tracker: decides source ready, which accepted beats are
// forwarded, and flags SOP/EOP framing violations (sticky until cleared).
module pkt_framing_fsm
    import pkt_stream_pkg::*;
#(
    parameter int unsigned STOP_AT_EOP = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_almost_full,
    input  logic i_valid,
    input  logic i_sop,
    input  logic i_eop,
    input  logic i_clr,
    output logic o_ready,
    output logic o_fwd,
    output logic o_proto_err
);

    localparam bit STOP_EN = (STOP_AT_EOP != 0);

    gate_state_e r_state;
    gate_state_e w_state_nxt;
    logic        r_af_q;
    logic        r_proto_err;
    logic        w_acc;
    logic        w_err_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_af_q      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_af_q  <= i_almost_full;
            if (i_clr) begin
                r_proto_err <= 1'b0;
            end else if (w_err_evt) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_fwd       = 1'b0;
        w_err_evt   = 1'b0;
        // Ready is forced low while reset is held so no beat is taken then.
        if (reset_n) begin
            o_ready = STOP_EN ? (r_state != HOLD) : !r_af_q;
        end
        w_acc = i_valid & o_ready;

        unique case (r_state)
            IDLE: begin
                if (w_acc && i_sop) begin
                    o_fwd = 1'b1;
                    if (!i_eop) begin
                        w_state_nxt = PKT;
                    end else if (STOP_EN && r_af_q) begin
                        w_state_nxt = HOLD;
                    end
                end else begin
                    // A beat without SOP between packets is discarded.
                    w_err_evt = w_acc;
                    if (STOP_EN && r_af_q) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            PKT: begin
                if (w_acc) begin
                    o_fwd     = 1'b1;
                    w_err_evt = i_sop;
                    if (i_eop) begin
                        w_state_nxt = (STOP_EN && r_af_q) ? HOLD : IDLE;
                    end
                end
            end
            HOLD: begin
                if (!r_af_q) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_proto_err = r_proto_err;

endmodule

// File: rtl/pkt_af_tx_gate.sv
// Transmit gate between a ready/valid packet source and an almost_full-throttled
// FIFO: registers forwarded beats and keeps packet/stall statistics.
module pkt_af_tx_gate
    import pkt_stream_pkg::*;
#(
    parameter int unsigned SYMBOLS_PER_BEAT = 64,
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    parameter int unsigned EMPTY_W          = EMPTY_W_DEF,
    parameter int unsigned STOP_AT_EOP      = 1,
    localparam int unsigned DATA_W          = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    input  logic               fifo_almost_full,
    input  logic               clr_stats,
    output logic [31:0]        pkt_cnt,
    output logic [31:0]        stall_cnt,
    output logic               proto_err
);

    logic               w_ready;
    logic               w_fwd;
    logic               w_fwd_eop;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_sop;
    logic               r_out_eop;
    logic [EMPTY_W-1:0] r_out_empty;
    logic [31:0]        r_pkt_cnt;
    logic [31:0]        r_stall_cnt;

    pkt_framing_fsm #(
        .STOP_AT_EOP (STOP_AT_EOP)
    ) u_framing (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_almost_full (fifo_almost_full),
        .i_valid       (in_valid),
        .i_sop         (in_startofpacket),
        .i_eop         (in_endofpacket),
        .i_clr         (clr_stats),
        .o_ready       (w_ready),
        .o_fwd         (w_fwd),
        .o_proto_err   (proto_err)
    );

    assign w_fwd_eop = w_fwd & in_endofpacket;

    // Non-forwarded cycles present an all-zero beat to the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= '0;
        end else begin
            r_out_valid <= w_fwd;
            r_out_data  <= w_fwd ? in_data : '0;
            r_out_sop   <= w_fwd & in_startofpacket;
            r_out_eop   <= w_fwd_eop;
            r_out_empty <= w_fwd_eop ? in_empty : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_cnt   <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else if (clr_stats) begin
            r_pkt_cnt   <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_fwd_eop) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (in_valid && !w_ready) begin
                r_stall_cnt <= sat_inc32(r_stall_cnt);
            end
        end
    end

    assign in_ready          = w_ready;
    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign out_empty         = r_out_empty;
    assign pkt_cnt           = r_pkt_cnt;
    assign stall_cnt         = r_stall_cnt;

endmodule
